// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: PC-side request, decode-side handoff and
// instruction-memory read handshake.
//   master : seen by the fetch unit (drives mem_req/mem_addr, instruction,
//            instr_valid, stall, fetch_fault, fetch_count)
//   slave  : seen by the surrounding PC / memory / decode environment
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  fetch_en;
    logic                  flush;
    logic                  decode_ready;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instr_valid;
    logic                  stall;
    logic                  fetch_fault;
    logic [31:0]           fetch_count;

    modport master (
        input  address, fetch_en, flush, decode_ready, mem_ack, mem_rdata,
        output mem_req, mem_addr, instruction, instr_valid, stall,
               fetch_fault, fetch_count
    );

    modport slave (
        output address, fetch_en, flush, decode_ready, mem_ack, mem_rdata,
        input  mem_req, mem_addr, instruction, instr_valid, stall,
               fetch_fault, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: takes the PC address, issues a handshaked read to
// instruction memory, holds the returned instruction until decode accepts it,
// and stalls the PC while a fetch is outstanding or unaccepted.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   bus    - instruction_fetch_unit_if.master (address, fetch_en, flush,
//            decode_ready, mem_req, mem_addr, mem_ack, mem_rdata,
//            instruction, instr_valid, stall, fetch_fault, fetch_count)
// Optional feature: define FETCH_COUNT_EN to build the completed-fetch
// counter on fetch_count; otherwise fetch_count is tied to zero.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    localparam int unsigned TMO_W    = 8;
    localparam int unsigned CNT_W    = 32;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_VALID
    } state_e;

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fetch_fault_q, fetch_fault_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  aligned_c;
    logic                  stall_c;

    assign aligned_c = (bus.address[1:0] == 2'b00);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            tmo_q         <= tmo_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = 1'b0;
        tmo_d         = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (!bus.flush && bus.fetch_en) begin
                    if (aligned_c) begin
                        mem_addr_d = bus.address;
                        mem_req_d  = 1'b1;
                        tmo_d      = '0;
                        state_d    = S_WAIT;
                    end else begin
                        fetch_fault_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (bus.flush) begin
                        // Branch redirect in the same cycle: drop the data
                        state_d = S_IDLE;
                    end else begin
                        instruction_d = bus.mem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = S_VALID;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fetch_fault_d = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // Request stays up; the pending ack is swallowed in DRAIN
                    if (bus.flush) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Timeout keeps counting from WAIT so total outstanding time is bounded
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    fetch_fault_d = 1'b1;
                    mem_req_d     = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_VALID: begin
                if (bus.flush) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end else if (bus.decode_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_IDLE;
                    if (bus.fetch_en) begin
                        if (aligned_c) begin
                            // Back-to-back fetch with no idle bubble
                            mem_addr_d = bus.address;
                            mem_req_d  = 1'b1;
                            tmo_d      = '0;
                            state_d    = S_WAIT;
                        end else begin
                            fetch_fault_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PC hold request, combinational so the PC freezes in the issuing cycle
    always_comb begin
        stall_c = 1'b0;
        unique case (state_q)
            S_IDLE:  stall_c = bus.fetch_en && aligned_c && !bus.flush;
            S_WAIT:  stall_c = 1'b1;
            S_DRAIN: stall_c = 1'b1;
            S_VALID: stall_c = !bus.decode_ready;
            default: stall_c = 1'b0;
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.stall       = stall_c;

`ifdef FETCH_COUNT_EN
    logic             fetch_done_c;
    logic [CNT_W-1:0] fetch_count_q;

    // A fetch completes on the WAIT->VALID transition only
    assign fetch_done_c = (state_q == S_WAIT) && bus.mem_ack && !bus.flush;

    // Completed-fetch counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else if (fetch_done_c) begin
            fetch_count_q <= fetch_count_q + CNT_W'(1);
        end
    end

    assign bus.fetch_count = fetch_count_q;
`else
    assign bus.fetch_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a per-cycle reference model
// and an accepted-instruction scoreboard.
module tb_instruction_fetch_unit;

    localparam int TMO = 4;

    logic clk;
    logic reset;

    instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    instruction_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Fetch outstanding / flushed-while-outstanding / instruction held.
    bit          m_init;
    bit          m_req;
    bit          m_discard;
    bit          m_valid;
    bit          m_fault;
    int          m_waited;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic [31:0] exp_q[$];

    function automatic void try_issue();
        if (bus.address[1:0] != 2'b00) begin
            m_fault = 1'b1;
        end else begin
            m_req     = 1'b1;
            m_addr    = bus.address;
            m_waited  = 0;
            m_discard = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1; m_req = 1'b0; m_discard = 1'b0; m_valid = 1'b0;
            m_fault = 1'b0; m_waited = 0; m_addr = '0; m_instr = '0; m_cnt = '0;
        end else begin
            m_fault = 1'b0;
            if (m_req) begin
                if (bus.mem_ack) begin
                    m_req = 1'b0;
                    if (!m_discard && !bus.flush) begin
                        m_instr = bus.mem_rdata;
                        m_valid = 1'b1;
                        m_cnt   = m_cnt + 32'd1;
                    end
                    m_discard = 1'b0;
                end else if (m_waited == TMO - 1) begin
                    m_fault = 1'b1; m_req = 1'b0; m_discard = 1'b0;
                end else begin
                    m_waited++;
                    if (bus.flush) m_discard = 1'b1;
                end
            end else if (m_valid) begin
                if (bus.flush) begin
                    m_valid = 1'b0;
                end else if (bus.decode_ready) begin
                    m_valid = 1'b0;
                    if (bus.fetch_en) try_issue();
                end
            end else if (!bus.flush && bus.fetch_en) begin
                try_issue();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_stall;
        logic [31:0] exp_cnt;
        if (m_init) begin
            exp_stall = m_req || (m_valid && !bus.decode_ready) ||
                        (!m_req && !m_valid && bus.fetch_en && !bus.flush &&
                         bus.address[1:0] == 2'b00);
`ifdef FETCH_COUNT_EN
            exp_cnt = m_cnt;
`else
            exp_cnt = 32'd0;
`endif
            chk("mem_req",     64'(bus.mem_req),     64'(m_req));
            chk("mem_addr",    64'(bus.mem_addr),    64'(m_addr));
            chk("instr_valid", 64'(bus.instr_valid), 64'(m_valid));
            chk("instruction", 64'(bus.instruction), 64'(m_instr));
            chk("fetch_fault", 64'(bus.fetch_fault), 64'(m_fault));
            chk("stall",       64'(bus.stall),       64'(exp_stall));
            chk("fetch_count", 64'(bus.fetch_count), 64'(exp_cnt));
            if (m_valid && bus.decode_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    chk("accept_unexpected", 64'(bus.instruction), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("accept_order", 64'(bus.instruction), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] b2b_data [3];
    logic [31:0] cnt_after_b2b;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b2b_data[0] = 32'hF940_0041;
        b2b_data[1] = 32'hCB03_0084;
        b2b_data[2] = 32'hB400_0060;
`ifdef FETCH_COUNT_EN
        cnt_after_b2b = 32'd4;
`else
        cnt_after_b2b = 32'd0;
`endif
        reset = 1'b1;
        bus.address = '0; bus.fetch_en = 1'b0; bus.flush = 1'b0;
        bus.decode_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        m_init = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_mem_req",     64'(bus.mem_req),     64'd0);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instruction", 64'(bus.instruction), 64'd0);
        chk("rst_fetch_fault", 64'(bus.fetch_fault), 64'd0);
        chk("rst_fetch_count", 64'(bus.fetch_count), 64'd0);

        // Basic fetch, ack in the first request cycle
        bus.address = 32'h0000_0004; bus.fetch_en = 1'b1;
        #1 chk("basic_stall_issue", 64'(bus.stall), 64'd1);
        tick();
        bus.fetch_en = 1'b0;
        chk("basic_mem_req",  64'(bus.mem_req),  64'd1);
        chk("basic_mem_addr", 64'(bus.mem_addr), 64'h4);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8B02_0020;
        exp_q.push_back(32'h8B02_0020);
        tick();
        bus.mem_ack = 1'b0;
        chk("basic_req_dropped", 64'(bus.mem_req),     64'd0);
        chk("basic_valid",       64'(bus.instr_valid), 64'd1);
        chk("basic_instr",       64'(bus.instruction), 64'h8B02_0020);
        tick();
        chk("basic_held_valid", 64'(bus.instr_valid), 64'd1);
        chk("basic_held_stall", 64'(bus.stall),       64'd1);
        bus.decode_ready = 1'b1;
        #1 chk("basic_accept_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.decode_ready = 1'b0;
        chk("basic_after_accept", 64'(bus.instr_valid), 64'd0);

        // Back-to-back fetches, ack latency 2
        bus.address = 32'h0; bus.fetch_en = 1'b1; bus.decode_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_req",  64'(bus.mem_req),  64'd1);
            chk("b2b_addr", 64'(bus.mem_addr), 64'(i * 4));
            tick();
            bus.mem_ack = 1'b1; bus.mem_rdata = b2b_data[i];
            exp_q.push_back(b2b_data[i]);
            tick();
            bus.mem_ack = 1'b0;
            chk("b2b_valid", 64'(bus.instr_valid), 64'd1);
            chk("b2b_instr", 64'(bus.instruction), 64'(b2b_data[i]));
            bus.address = 32'((i + 1) * 4);
            if (i == 2) bus.fetch_en = 1'b0;
        end
        tick();
        bus.decode_ready = 1'b0;
        chk("b2b_idle_req",    64'(bus.mem_req),     64'd0);
        chk("b2b_fetch_count", 64'(bus.fetch_count), 64'(cnt_after_b2b));

        // Flush in the first WAIT cycle, ack arrives in the 4th request cycle
        bus.address = 32'h10; bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("drain_req_held", 64'(bus.mem_req), 64'd1);
        chk("drain_stall",    64'(bus.stall),   64'd1);
        tick();
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0;
        chk("drain_req_drop", 64'(bus.mem_req),     64'd0);
        chk("drain_no_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        chk("drain_count_kept", 64'(bus.fetch_count), 64'(cnt_after_b2b));

        // Misaligned address
        bus.address = 32'h6; bus.fetch_en = 1'b1;
        #1 chk("misal_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.fetch_en = 1'b0;
        chk("misal_fault", 64'(bus.fetch_fault), 64'd1);
        chk("misal_no_req", 64'(bus.mem_req),    64'd0);
        tick();
        chk("misal_fault_pulse", 64'(bus.fetch_fault), 64'd0);

        // Timeout with no ack, then a stray ack
        bus.address = 32'h20; bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tmo_req_held", 64'(bus.mem_req),     64'd1);
            chk("tmo_no_fault", 64'(bus.fetch_fault), 64'd0);
        end
        tick();
        chk("tmo_fault",    64'(bus.fetch_fault), 64'd1);
        chk("tmo_req_drop", 64'(bus.mem_req),     64'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_valid", 64'(bus.instr_valid), 64'd0);
        chk("stray_ack_fault", 64'(bus.fetch_fault), 64'd0);

        // Flush wins over decode_ready in VALID
        bus.address = 32'h40; bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h9100_0421;
        tick();
        bus.mem_ack = 1'b0;
        chk("vflush_valid", 64'(bus.instr_valid), 64'd1);
        bus.decode_ready = 1'b1; bus.flush = 1'b1;
        tick();
        bus.decode_ready = 1'b0; bus.flush = 1'b0;
        chk("vflush_dropped", 64'(bus.instr_valid), 64'd0);

        // Reset mid-WAIT, then a late ack
        bus.address = 32'h30; bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0;
        chk("rmid_req", 64'(bus.mem_req), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_req_zero",   64'(bus.mem_req),     64'd0);
        chk("rmid_addr_zero",  64'(bus.mem_addr),    64'd0);
        chk("rmid_instr_zero", 64'(bus.instruction), 64'd0);
        chk("rmid_count_zero", 64'(bus.fetch_count), 64'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
        tick();
        bus.mem_ack = 1'b0;
        chk("rmid_ack_ignored", 64'(bus.instr_valid), 64'd0);
        tick();
        chk("rmid_still_idle", 64'(bus.mem_req), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Consumer of the program counter's `address` output.
- Accepts the current PC value, issues a handshaked read to instruction memory, and holds the returned 32-bit LEGv8 instruction for decode.
- Drives `stall` back to the PC path so the address holds while a fetch is outstanding.
- Supports pipeline flush on branches and a memory timeout.

Parameters:
- ADDR_WIDTH, 32, width of `address` and `mem_addr`.
- DATA_WIDTH, 32, width of `mem_rdata` and `instruction`.
- MEM_TIMEOUT, 15, maximum wait cycles for `mem_ack` before fault; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  current PC value.
- fetch_en  input  1  request a fetch of `address`.
- flush  input  1  discard the in-flight or held instruction (branch taken).
- decode_ready  input  1  decode accepts `instruction` this cycle.
- mem_req  output  1  memory read request, registered.
- mem_addr  output  ADDR_WIDTH  memory read address, registered.
- mem_ack  input  1  memory data valid this cycle.
- mem_rdata  input  DATA_WIDTH  memory read data.
- instruction  output  DATA_WIDTH  held instruction, registered.
- instr_valid  output  1  `instruction` is valid.
- stall  output  1  PC must hold (combinational from state and inputs).
- fetch_fault  output  1  one-cycle pulse: misaligned address or timeout.
- fetch_count  output  32  completed fetch count; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - State is IDLE.
  - mem_req=0, mem_addr=0, instruction=0, instr_valid=0, fetch_fault=0, timeout counter=0, fetch_count=0.
- States: IDLE, WAIT, DRAIN, VALID.
- IDLE:
  - flush has priority over fetch_en; with flush high, stay IDLE.
  - fetch_en && address[1:0]!=0: fetch_fault=1 for one cycle, no request, stay IDLE.
  - fetch_en && aligned: next edge mem_addr<=address, mem_req<=1, counter<=0, go WAIT.
- WAIT:
  - mem_req and mem_addr are held stable until ack.
  - mem_ack: instruction<=mem_rdata, instr_valid<=1, mem_req<=0, go VALID. instr_valid therefore rises the edge after ack is sampled.
  - flush without ack: go DRAIN; mem_req stays high until ack.
  - flush with ack in the same cycle: data discarded, mem_req<=0, go IDLE, no instr_valid.
  - counter increments each cycle with no ack. When counter==MEM_TIMEOUT-1 and no ack: fetch_fault pulse, mem_req<=0, go IDLE.
- DRAIN:
  - Wait for mem_ack, then mem_req<=0, go IDLE; data discarded.
  - The same timeout rule as WAIT applies.
- VALID:
  - instruction and instr_valid are held until decode_ready.
  - flush: instr_valid<=0, go IDLE. flush wins over decode_ready.
  - decode_ready with fetch_en and aligned address: back-to-back fetch. instr_valid<=0, mem_addr<=address, mem_req<=1, go WAIT.
  - decode_ready with fetch_en and misaligned address: fetch_fault pulse, go IDLE.
  - decode_ready otherwise: instr_valid<=0, go IDLE.
- stall=1 when any of:
  - state is WAIT or DRAIN;
  - state is VALID && !decode_ready;
  - state is IDLE && fetch_en && aligned && !flush.
- mem_ack outside WAIT or DRAIN is ignored. This covers a late ack after reset or after a timeout.
- Reset mid-WAIT: mem_req drops on that edge and no instruction is delivered.
- Minimum latency: fetch_en at cycle 0, mem_req at 1, ack at 1, instr_valid at 2.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined: 32-bit counter increments on every WAIT→VALID transition and wraps 0xFFFFFFFF→0. It is cleared by reset and is not changed by flush or by discarded fetches. It drives fetch_count.
- Undefined: no counter logic is built; fetch_count is tied to 0.

Test Plan:
- Basic fetch: reset, then address=0x00000004, fetch_en=1, ack one cycle after req with mem_rdata=0x8B020020.
  - Required: mem_addr=0x4, mem_req high for exactly 1 cycle, instr_valid=1 with instruction=0x8B020020 held until decode_ready, stall high until accept.
- Back-to-back fetches: addresses 0x0, 0x4, 0x8 with decode_ready=1 and ack latency 2.
  - Required: three instructions delivered in order, no idle cycle between VALID and the next req, fetch_count=3 with FETCH_COUNT_EN.
- Flush in WAIT: assert flush 1 cycle after req, ack 3 cycles later.
  - Required: state DRAIN, mem_req held until ack, instr_valid never rises, fetch_count unchanged.
- Misaligned address: address=0x00000006, fetch_en=1.
  - Required: fetch_fault pulse of 1 cycle, mem_req stays 0.
- Timeout: MEM_TIMEOUT=4, never ack.
  - Required: fetch_fault after 4 WAIT cycles, mem_req drops, IDLE; a later stray mem_ack is ignored.
- Reset mid-operation: assert reset during WAIT, then ack arrives.
  - Required: all outputs 0 on the next edge, ack ignored, instr_valid stays 0.
